divider_ratio_scheduler: RTL
============================

// Module: divider_ratio_scheduler
// PURPOSE
//  Owns the mc (divide ratio) input of the programmable frequency divider and shares it among NUM_REQ
//  requesters. Round-robin arbitration picks one ratio-change request, applies it only at a divider
//  output period boundary, pulses the divider's sync reset, waits SETTLE_PERIODS output periods, then
//  acknowledges the requester. Sits between the clock-config clients and the divider instance.
// PARAMETERS
//  NUM_REQ        4   number of requesters (2..8)
//  MC_W           4   width of mc; matches the divider's mc port
//  MC_RESET       2   mc_out value after reset
//  MC_MIN         1   smallest legal mc; lower requests are rejected
//  SETTLE_PERIODS 2   divider output rising edges counted after load before ack (1..15)
//  EDGE_TIMEOUT   64  clk cycles to wait for any single div_clk_out rising edge before proceeding anyway
// PORTS
//  clk          in   1            system clock, same clock that drives the divider
//  reset        in   1            asynchronous, active-low reset
//  req_valid    in   NUM_REQ      request i wants mc = req_mc[i]; held until req_ready[i]
//  req_mc       in   NUM_REQ*MC_W packed ratios, slice i = [i*MC_W +: MC_W]
//  req_ready    out  NUM_REQ      one-cycle completion pulse to the granted requester
//  req_err      out  1            qualifies req_ready: 1 = request rejected (mc < MC_MIN)
//  div_clk_out  in   1            divider clk_out, fed back for boundary detection
//  mc_out       out  MC_W         ratio driven to the divider's mc input
//  div_reset    out  1            active-high sync reset to the divider
//  busy         out  1            1 in any state except IDLE
//  active_id    out  $clog2(NUM_REQ) index of the request in progress (0 when idle)
// BEHAVIOUR
//  Reset (async assert): state=IDLE, mc_out=MC_RESET, div_reset=1, req_ready=0, req_err=0, busy=0,
//   active_id=0, rr pointer=0, counters=0. div_reset clears on the first clk edge after release.
//  div_clk_out passes through 2 sync flops. rise = sync2 & ~sync3. All boundary and settle decisions
//   use rise, so there are 3 clk of latency from a divider edge to an action.
//  IDLE: if any req_valid, the rr arbiter grants the first valid index at or after the pointer.
//   Latch id and mc. Pointer <= id+1 mod NUM_REQ.
//   - Latched mc < MC_MIN: req_ready[id]=1 and req_err=1 next cycle. Stay IDLE. mc_out unchanged.
//   - Latched mc == mc_out: go to SETTLE with count=0. No div_reset.
//   - Otherwise go to WAIT_EDGE.
//  WAIT_EDGE: on rise, or on timer == EDGE_TIMEOUT-1, go to LOAD. The timer restarts on entry.
//  LOAD (1 cycle): mc_out <= latched mc, div_reset=1 for exactly this cycle, then SETTLE.
//  SETTLE: count rise events. At count == SETTLE_PERIODS, pulse req_ready[id] (req_err=0) and go
//   to IDLE. The timeout timer restarts after each rise. On timeout the state advances as if a rise
//   occurred.
//  At most one req_ready bit is high in any cycle. req_err=0 whenever req_ready==0.
//  Requests are latched at grant. Later changes to req_mc or req_valid have no effect until
//   req_ready. If valid is still high in the cycle after req_ready, it is a new request.
//  A request that is not granted waits. Round-robin bounds the wait to NUM_REQ-1 other grants.
//  Reset mid-operation: immediate return to IDLE, mc_out=MC_RESET, and the pending request gets no
//   ack. Requesters must re-issue.
//  The timer is $clog2(EDGE_TIMEOUT) bits wide and the settle counter is 4 bits; neither wraps, both
//   saturate at their terminal value. mc is unsigned with no arithmetic, so it is never wrapped.
// STRUCTURE
//  Shared package divider_ctrl_pkg: state encoding (IDLE, WAIT_EDGE, LOAD, SETTLE) as localparams,
//   the default MC_W, and MC_RESET.
//  Sub-module rr_arbiter #(N): inputs req and ptr, outputs grant_valid and grant_id. Purely
//   combinational. Reused by other clock-config blocks.
//  Everything else (edge sync, FSM, counters) lives in this module.
// TESTING
//  Use a real divider instance as the DUT load. Check that div_clk_out has no runt pulse across any
//   update.
//  1 Reset release, no requests -> mc_out=2. div_reset=1 until first edge, then 0. busy=0.
//  2 req_valid[1], req_mc=5 -> WAIT_EDGE; after rise, one cycle of div_reset with mc_out=5; after 2
//   rises, req_ready=4'b0010 for 1 cycle, req_err=0.
//  3 req_valid=4'b1111 with mcs 3,4,5,6 at ptr=0 -> grant order 0,1,2,3; final mc_out=6;
//   4 ready pulses, none overlapping.
//  4 req_mc=0 -> req_ready pulse with req_err=1 the next cycle; mc_out and div_reset unchanged.
//  5 div_clk_out tied low, request mc=7 -> LOAD after 64 cycles; ack after further timeouts;
//   busy throughout.
//  6 Assert reset during SETTLE -> mc_out=2 and IDLE at once; no req_ready; a re-issued request
//   completes normally.

Source files
------------

// File: rtl/divider_ctrl_pkg.sv
// Shared definitions for the clock-config control blocks: FSM state encoding,
// default ratio width/reset value, and a width helper for counters and indices.
package divider_ctrl_pkg;

  localparam int MC_W_DEFAULT     = 4;
  localparam int MC_RESET_DEFAULT = 2;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_EDGE = 2'd1;
  localparam logic [1:0] ST_LOAD      = 2'd2;
  localparam logic [1:0] ST_SETTLE    = 2'd3;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo N.
module rr_arbiter
  import divider_ctrl_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = width_of(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_id
);

  logic [IW-1:0] idx;

  // Scan from the farthest candidate toward ptr so the nearest valid one wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/divider_ratio_scheduler.sv
// Shares the divider's mc input among NUM_REQ requesters: round-robin grant,
// load at a divider output boundary with a sync-reset pulse, settle, then ack.
module divider_ratio_scheduler
  import divider_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MC_W           = MC_W_DEFAULT,
  parameter int MC_RESET       = MC_RESET_DEFAULT,
  parameter int MC_MIN         = 1,
  parameter int SETTLE_PERIODS = 2,
  parameter int EDGE_TIMEOUT   = 64,
  localparam int ID_W          = width_of(NUM_REQ),
  localparam int TMR_W         = width_of(EDGE_TIMEOUT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*MC_W-1:0]  req_mc,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     req_err,
  input  logic                     div_clk_out,
  output logic [MC_W-1:0]          mc_out,
  output logic                     div_reset,
  output logic                     busy,
  output logic [ID_W-1:0]          active_id
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(EDGE_TIMEOUT - 1);
  localparam logic [3:0]       CNT_LAST = 4'(SETTLE_PERIODS - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [MC_W-1:0]    mc_lat_q, mc_lat_d;
  logic [MC_W-1:0]    mc_out_q, mc_out_d;
  logic               div_reset_q, div_reset_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               err_q, err_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               sync1_q, sync2_q, sync3_q;

  logic               rise;
  logic               timeout;
  logic               edge_event;
  logic [NUM_REQ-1:0] arb_req;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic [MC_W-1:0]    grant_mc;
  logic [ID_W-1:0]    grant_next;

  // The requester still holds valid during its ack cycle; mask so it is not re-granted.
  assign arb_req = req_valid & {NUM_REQ{~|ready_q}};

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req         (arb_req),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign grant_mc   = req_mc[grant_id*MC_W +: MC_W];
  assign grant_next = (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;

  assign rise       = sync2_q & ~sync3_q;
  assign timeout    = (tmr_q == TMR_LAST);
  assign edge_event = rise | timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= div_clk_out;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    mc_lat_d    = mc_lat_q;
    mc_out_d    = mc_out_q;
    div_reset_d = 1'b0;
    ready_d     = '0;
    err_d       = 1'b0;
    tmr_d       = timeout ? tmr_q : tmr_q + 1'b1;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        cnt_d = '0;
        if (grant_valid) begin
          id_d     = grant_id;
          mc_lat_d = grant_mc;
          ptr_d    = grant_next;
          if (grant_mc < MC_W'(MC_MIN)) begin
            ready_d = NUM_REQ'(1) << grant_id;
            err_d   = 1'b1;
          end else if (grant_mc == mc_out_q) begin
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_WAIT_EDGE;
          end
        end
      end

      ST_WAIT_EDGE: begin
        if (edge_event) begin
          state_d     = ST_LOAD;
          mc_out_d    = mc_lat_q;
          div_reset_d = 1'b1;
          tmr_d       = '0;
        end
      end

      ST_LOAD: begin
        state_d = ST_SETTLE;
        tmr_d   = '0;
        cnt_d   = '0;
      end

      ST_SETTLE: begin
        // A timeout counts as a period so a stalled divider cannot hang the requester.
        if (edge_event) begin
          tmr_d = '0;
          if (cnt_q >= CNT_LAST) begin
            ready_d = NUM_REQ'(1) << id_q;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      ptr_q       <= '0;
      mc_lat_q    <= '0;
      mc_out_q    <= MC_W'(MC_RESET);
      div_reset_q <= 1'b1;
      ready_q     <= '0;
      err_q       <= 1'b0;
      tmr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      mc_lat_q    <= mc_lat_d;
      mc_out_q    <= mc_out_d;
      div_reset_q <= div_reset_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      tmr_q       <= tmr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = ready_q;
  assign req_err   = err_q;
  assign mc_out    = mc_out_q;
  assign div_reset = div_reset_q;
  assign busy      = (state_q != ST_IDLE);
  assign active_id = busy ? id_q : '0;

endmodule
